// File: rtl/scr1_pipe_mprf_sb.sv
// Multi-port register file (x0 hardwired to zero) with an integrated per-register scoreboard.
// Optional macro SCR1_MPRF_WR_BYPASS_EN selects write-first reads; when it is undefined, reads are read-first.
module scr1_pipe_mprf_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int RD_LAT = 0,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_req_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                rsv_req_i,
    input  logic [AW-1:0]       rsv_addr_i,
    output logic                rsv_stall_o,
    input  logic                flush_i,
    output logic [AW:0]         pend_cnt_o
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pend, pend_nxt, clr;
    logic [AW:0]      cnt_nxt;
    logic             rsv_ok;

    // Storage is deliberately left unreset; a later write port overrides an earlier one.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NWR; j++)
            if (wr_req_i[j] && wr_addr_i[j*AW +: AW] != '0)
                mem[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
    end

    always_comb begin
        clr = '0;
        for (int j = 0; j < NWR; j++)
            if (wr_req_i[j] && wr_addr_i[j*AW +: AW] != '0)
                clr[wr_addr_i[j*AW +: AW]] = 1'b1;
    end

    // A writeback to the reserved register hands ownership over, so it does not stall.
    assign rsv_ok      = rsv_req_i && rsv_addr_i != '0 && !flush_i;
    assign rsv_stall_o = rsv_ok && pend[rsv_addr_i] && !clr[rsv_addr_i];

    always_comb begin
        pend_nxt = pend & ~clr;
        if (rsv_ok && !rsv_stall_o)
            pend_nxt[rsv_addr_i] = 1'b1;
        if (flush_i)
            pend_nxt = '0;
        cnt_nxt = '0;
        for (int k = 0; k < NREGS; k++)
            cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= '0;
            pend_cnt_o <= '0;
        end else begin
            pend       <= pend_nxt;
            pend_cnt_o <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        assign ra = rd_addr_i[i*AW +: AW];

        always_comb begin
            rdat = mem[ra];
`ifdef SCR1_MPRF_WR_BYPASS_EN
            for (int j = 0; j < NWR; j++)
                if (wr_req_i[j] && wr_addr_i[j*AW +: AW] == ra)
                    rdat = wr_data_i[j*XLEN +: XLEN];
`endif
        end

`ifdef SCR1_MPRF_WR_BYPASS_EN
        assign rd_busy_o[i] = pend[ra] & ~clr[ra];
`else
        assign rd_busy_o[i] = pend[ra];
`endif

        if (RD_LAT == 0) begin : g_async
            assign rd_data_o[i*XLEN +: XLEN] = (ra == '0) ? '0 : rdat;
        end else begin : g_sync
            logic [XLEN-1:0] rd_q;
            logic            rd_z;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                    rd_z <= 1'b0;
                end else begin
                    rd_q <= rdat;
                    rd_z <= (ra == '0);
                end
            end
            assign rd_data_o[i*XLEN +: XLEN] = rd_z ? '0 : rd_q;
        end
    end

endmodule

// File: tb/tb_scr1_pipe_mprf_sb.sv
// Directed bench: an asynchronous-read and a registered-read instance share stimulus, both with NWR=2.
module tb_scr1_pipe_mprf_sb;

`ifdef SCR1_MPRF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [1:0]  wr_req = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_req = 1'b0, flush = 1'b0;
    logic [4:0]  rsv_addr = '0;

    logic [63:0] rd0, rd1;
    logic [1:0]  busy0, busy1;
    logic        stall0, stall1;
    logic [5:0]  cnt0, cnt1;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    scr1_pipe_mprf_sb #(.NWR(2), .RD_LAT(0)) u_async (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd0), .rd_busy_o(busy0),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .rsv_stall_o(stall0),
        .flush_i(flush), .pend_cnt_o(cnt0));

    scr1_pipe_mprf_sb #(.NWR(2), .RD_LAT(1)) u_sync (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd1), .rd_busy_o(busy1),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_req_i(rsv_req), .rsv_addr_i(rsv_addr), .rsv_stall_o(stall1),
        .flush_i(flush), .pend_cnt_o(cnt1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_req = '0; rsv_req = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        chk({tag, "_cnt_async"}, 64'(cnt0), 64'(exp));
        chk({tag, "_cnt_sync"},  64'(cnt1), 64'(exp));
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stall_async"}, 64'(stall0), 64'(exp));
        chk({tag, "_stall_sync"},  64'(stall1), 64'(exp));
    endtask

    task automatic chk_busy0(input string tag, input logic exp);
        chk({tag, "_busy_async"}, 64'(busy0[0]), 64'(exp));
        chk({tag, "_busy_sync"},  64'(busy1[0]), 64'(exp));
    endtask

    initial begin
        // Reset state
        #1;
        chk_cnt("rst", 0);
        chk_stall("rst", 1'b0);
        chk("rst_busy_async", 64'(busy0), 64'd0);
        chk("rst_rd_sync", rd1, 64'd0);
        #11 rst = 1'b0;
        tick;

        // Write x5, read it on both ports
        wr_req = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
        tick;
        idle; rd_addr = {5'd5, 5'd5};
        #1;
        chk("x5_async_p0", rd0[31:0], 64'hDEADBEEF);
        chk("x5_async_p1", rd0[63:32], 64'hDEADBEEF);
        tick;
        chk("x5_sync_p0", rd1[31:0], 64'hDEADBEEF);
        chk("x5_sync_p1", rd1[63:32], 64'hDEADBEEF);

        // Write to x0 is discarded
        wr_req = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h1234}; rd_addr = {5'd5, 5'd0};
        tick;
        idle;
        #1;
        chk("x0_async", rd0[31:0], 64'd0);
        tick;
        chk("x0_sync", rd1[31:0], 64'd0);

        // Same-cycle write/read of x7
        wr_req = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'h11111111};
        tick;
        wr_data = {32'd0, 32'hA5A5A5A5}; rd_addr = {5'd5, 5'd7};
        #1;
        chk("x7_same_async", rd0[31:0], BYP ? 64'hA5A5A5A5 : 64'h11111111);
        tick;
        idle;
        chk("x7_same_sync", rd1[31:0], BYP ? 64'hA5A5A5A5 : 64'h11111111);
        chk("x7_after_async", rd0[31:0], 64'hA5A5A5A5);

        // Reserve x3, re-reserve stalls, writeback clears
        rsv_req = 1'b1; rsv_addr = 5'd3; rd_addr = {5'd0, 5'd3};
        #1;
        chk_stall("rsv3", 1'b0);
        tick;
        chk_cnt("rsv3", 1);
        chk_busy0("rsv3", 1'b1);
        chk_stall("rsv3_again", 1'b1);
        tick;
        chk_cnt("rsv3_again", 1);
        rsv_req = 1'b0; wr_req = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'h33};
        #1;
        chk_busy0("wr3_same", BYP ? 1'b0 : 1'b1);
        tick;
        idle;
        chk_cnt("wr3", 0);
        chk_busy0("wr3", 1'b0);

        // Reserve x4 while it is being written back
        rsv_req = 1'b1; rsv_addr = 5'd4; rd_addr = {5'd0, 5'd4};
        tick;
        chk_cnt("rsv4", 1);
        wr_req = 2'b01; wr_addr = {5'd0, 5'd4};
        #1;
        chk_stall("rsv4_wr4", 1'b0);
        tick;
        idle;
        chk_cnt("rsv4_wr4", 1);
        chk_busy0("rsv4_wr4", 1'b1);
        wr_req = 2'b01;
        tick;
        idle;
        chk_cnt("wr4", 0);

        // Both write ports hit x9: port 1 wins
        wr_req = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'h0000BBBB, 32'h0000AAAA}; rd_addr = {5'd9, 5'd0};
        tick;
        idle;
        #1;
        chk("x9_async", rd0[63:32], 64'h0000BBBB);
        tick;
        chk("x9_sync", rd1[63:32], 64'h0000BBBB);

        // Reserve x1,x2,x6 then flush with a competing reservation of x8
        rsv_req = 1'b1;
        rsv_addr = 5'd1; tick;
        rsv_addr = 5'd2; tick;
        rsv_addr = 5'd6; tick;
        chk_cnt("rsv126", 3);
        rsv_addr = 5'd8; flush = 1'b1; rd_addr = {5'd0, 5'd8};
        tick;
        idle;
        chk_cnt("flush", 0);
        chk_busy0("flush_x8", 1'b0);

        // Flush forces stall low even on a pending register
        rsv_req = 1'b1; rsv_addr = 5'd1;
        tick;
        flush = 1'b1;
        #1;
        chk_stall("flush_stall", 1'b0);
        tick;
        idle;
        chk_cnt("flush2", 0);

        // Asynchronous reset pulse between clock edges
        rsv_req = 1'b1;
        rsv_addr = 5'd10; tick;
        rsv_addr = 5'd11; rd_addr = {5'd0, 5'd5}; tick;
        idle;
        chk_cnt("pre_rst", 2);
        chk("pre_rst_sync_rd", rd1[31:0], 64'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk_cnt("mid_rst", 0);
        chk("mid_rst_sync_rd", rd1[31:0], 64'd0);
        rsv_addr = 5'd10; rd_addr = {5'd0, 5'd10};
        chk_busy0("mid_rst", 1'b0);
        rst = 1'b0;
        tick;
        chk_cnt("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
